// File: rtl/ram32x4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram32x4_arbiter
// Purpose  : Shares one single-port synchronous RAM between two requesters
//            (A and B) with round-robin arbitration, one access per cycle,
//            and a built-in sweep that writes CLEAR_VAL to every word.
//            Grants are combinational; read data returns on the shared
//            ram_data_out bus one cycle after the grant, qualified by the
//            requester's registered rvalid.
// Revision : 1.0  initial release
// ============================================================================
module ram32x4_arbiter #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,

    // Requester A
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    // Requester B
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    // Clear sequencer
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,

    // RAM side
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]        c_S_ARB     = 1'b0;
    localparam logic [0:0]        c_S_CLEAR   = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic              r_last_b;       // 1: B was granted most recently
    logic [ADDR_W-1:0] r_clear_cnt;    // sweep address
    logic              r_clear_done;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [ADDR_W-1:0] r_addr_last;    // RAM address holds between accesses
    logic [DATA_W-1:0] r_wdata_last;   // write data bus holds likewise

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [0:0]        w_next_state;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_address;
    logic [DATA_W-1:0] w_ram_data_in;
    logic              w_sweep_last;

    // The sweep is on its final word when the counter reaches the top address.
    assign w_sweep_last = (r_clear_cnt == c_LAST_ADDR);

    // State register: reset always lands in ARB, aborting any sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a clear pulse in ARB starts a sweep; the sweep ends
    // after the top address is written. Pulses during a sweep are ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_ARB: begin
                if (clear_start) begin
                    w_next_state = c_S_CLEAR;
                end
            end
            c_S_CLEAR: begin
                if (w_sweep_last) begin
                    w_next_state = c_S_ARB;
                end
            end
            default: begin
                w_next_state = c_S_ARB;
            end
        endcase
    end

    // Output logic: round-robin grant in ARB, sweep writes in CLEAR, and the
    // RAM bus steered from whichever source owns this cycle. Reset silences
    // every grant and write.
    always_comb begin
        w_grant_a     = 1'b0;
        w_grant_b     = 1'b0;
        w_ram_we      = 1'b0;
        w_ram_address = r_addr_last;
        w_ram_data_in = r_wdata_last;
        if (!reset) begin
            case (r_state)
                c_S_ARB: begin
                    // With both requesting, A wins only if B went last.
                    if (a_req && (!b_req || r_last_b)) begin
                        w_grant_a = 1'b1;
                    end else if (b_req) begin
                        w_grant_b = 1'b1;
                    end

                    if (w_grant_a) begin
                        w_ram_address = a_addr;
                        w_ram_data_in = a_wdata;
                        w_ram_we      = a_we;
                    end else if (w_grant_b) begin
                        w_ram_address = b_addr;
                        w_ram_data_in = b_wdata;
                        w_ram_we      = b_we;
                    end
                end
                c_S_CLEAR: begin
                    w_ram_address = r_clear_cnt;
                    w_ram_data_in = CLEAR_VAL;
                    w_ram_we      = 1'b1;
                end
                default: begin
                    w_ram_we = 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer: remembers which requester was served last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (w_grant_a) begin
            r_last_b <= 1'b0;
        end else if (w_grant_b) begin
            r_last_b <= 1'b1;
        end
    end

    // Read-valid flags: a granted read's data appears on the RAM output
    // exactly one cycle later, so the flag is the grant delayed by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_grant_a && !a_we;
            r_b_rvalid <= w_grant_b && !b_we;
        end
    end

    // Sweep counter and completion pulse: the counter starts at zero on
    // entry to CLEAR and advances once per written word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clear_cnt  <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= (r_state == c_S_CLEAR) && w_sweep_last;
            if (r_state == c_S_CLEAR) begin
                r_clear_cnt <= r_clear_cnt + 1'b1;
            end else begin
                r_clear_cnt <= '0;
            end
        end
    end

    // Bus hold registers: keep the RAM address and data steady when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_last  <= '0;
            r_wdata_last <= '0;
        end else begin
            r_addr_last  <= w_ram_address;
            r_wdata_last <= w_ram_data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign a_gnt            = w_grant_a;
    assign b_gnt            = w_grant_b;
    assign a_rvalid         = r_a_rvalid;
    assign b_rvalid         = r_b_rvalid;
    assign a_rdata          = ram_data_out;
    assign b_rdata          = ram_data_out;
    assign clear_busy       = (r_state == c_S_CLEAR);
    assign clear_done       = r_clear_done;
    assign ram_address      = w_ram_address;
    assign ram_data_in      = w_ram_data_in;
    assign ram_write_enable = w_ram_we;

endmodule
`default_nettype wire

// File: tb/tb_ram32x4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram32x4_arbiter
// Purpose  : Self-checking bench for ram32x4_arbiter. A 32x4 synchronous RAM
//            sits on the RAM port; a reference model of the arbiter and its
//            memory is compared against the DUT every cycle, and directed
//            scenarios carry hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram32x4_arbiter;

    logic       clk;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [4:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [3:0] a_rdata, b_rdata;
    logic       clear_start, clear_busy, clear_done;
    logic [4:0] ram_address;
    logic [3:0] ram_data_in;
    logic       ram_write_enable;
    logic [3:0] ram_data_out;

    int n_vec = 0;
    int n_bad = 0;

    ram32x4_arbiter #(
        .ADDR_W    (5),
        .DATA_W    (4),
        .CLEAR_VAL (4'h0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_wdata          (a_wdata),
        .a_gnt            (a_gnt),
        .a_rvalid         (a_rvalid),
        .a_rdata          (a_rdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_addr           (b_addr),
        .b_wdata          (b_wdata),
        .b_gnt            (b_gnt),
        .b_rvalid         (b_rvalid),
        .b_rdata          (b_rdata),
        .clear_start      (clear_start),
        .clear_busy       (clear_busy),
        .clear_done       (clear_done),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_data_out     (ram_data_out)
    );

    // Clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical RAM attached to the DUT: registered read, one-cycle latency
    logic [3:0] ram_array [32];
    always @(posedge clk) begin
        if (ram_write_enable) ram_array[ram_address] <= ram_data_in;
        ram_data_out <= ram_array[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: memory contents, who was served last, sweep progress
    // ------------------------------------------------------------------------
    logic [3:0] m_mem [32];
    bit         m_last_b    = 1'b1;
    bit         m_sweeping  = 1'b0;
    int         m_sweep_adr = 0;
    bit         m_busy      = 1'b0;
    bit         m_done      = 1'b0;
    bit         m_a_rv      = 1'b0;
    bit         m_b_rv      = 1'b0;
    logic [3:0] m_rdata     = 4'h0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_array[i] = 4'hF ^ 4'(i);
            m_mem[i]     = 4'hF ^ 4'(i);
        end
    end

    // Compare DUT with model mid-cycle, then advance the model past the edge
    always @(negedge clk) begin : model
        bit         ga, gb, we_e;
        logic [4:0] ad_e;
        logic [3:0] wd_e;

        ga = 1'b0;
        gb = 1'b0;
        if (!reset && !m_sweeping) begin
            if (a_req && b_req) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
        we_e = !reset && (m_sweeping || (ga && a_we) || (gb && b_we));
        ad_e = m_sweeping ? 5'(m_sweep_adr) : (ga ? a_addr : b_addr);
        wd_e = m_sweeping ? 4'h0 : (ga ? a_wdata : b_wdata);

        chk("m a_gnt", 32'(a_gnt), 32'(ga));
        chk("m b_gnt", 32'(b_gnt), 32'(gb));
        chk("m ram_we", 32'(ram_write_enable), 32'(we_e));
        if (we_e) begin
            chk("m ram_address", 32'(ram_address), 32'(ad_e));
            chk("m ram_data_in", 32'(ram_data_in), 32'(wd_e));
        end
        chk("m clear_busy", 32'(clear_busy), 32'(m_busy));
        chk("m clear_done", 32'(clear_done), 32'(m_done));
        chk("m a_rvalid", 32'(a_rvalid), 32'(m_a_rv));
        chk("m b_rvalid", 32'(b_rvalid), 32'(m_b_rv));
        if (m_a_rv) chk("m a_rdata", 32'(a_rdata), 32'(m_rdata));
        if (m_b_rv) chk("m b_rdata", 32'(b_rdata), 32'(m_rdata));

        if (reset) begin
            m_sweeping = 1'b0;
            m_last_b   = 1'b1;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_a_rv     = 1'b0;
            m_b_rv     = 1'b0;
        end else begin
            m_done = m_sweeping && (m_sweep_adr == 31);
            m_a_rv = ga && !a_we;
            m_b_rv = gb && !b_we;
            if (ga) m_rdata = m_mem[a_addr];
            if (gb) m_rdata = m_mem[b_addr];
            if (we_e) m_mem[ad_e] = wd_e;
            if (ga) m_last_b = 1'b0;
            if (gb) m_last_b = 1'b1;
            if (m_sweeping) begin
                m_sweep_adr++;
                if (m_sweep_adr == 32) m_sweeping = 1'b0;
            end else if (clear_start) begin
                m_sweeping  = 1'b1;
                m_sweep_adr = 0;
            end
            m_busy = m_sweeping;
        end
    end

    // ------------------------------------------------------------------------
    // Directed scenarios with literal expectations
    // ------------------------------------------------------------------------
    initial begin
        int busy_cycles;
        bit seen_done;

        reset = 1'b1; clear_start = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'h03; a_wdata = 4'h9;
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'h04; b_wdata = 4'h9;
        cyc();
        @(negedge clk);
        chk("reset a_gnt", 32'(a_gnt), 0);
        chk("reset b_gnt", 32'(b_gnt), 0);
        chk("reset ram_we", 32'(ram_write_enable), 0);
        chk("reset clear_busy", 32'(clear_busy), 0);
        chk("reset a_rvalid", 32'(a_rvalid), 0);

        // A writes 0xA at 0x15
        cyc(); reset = 1'b0; b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'h15; a_wdata = 4'hA;
        @(negedge clk);
        chk("wr a_gnt", 32'(a_gnt), 1);
        chk("wr ram_address", 32'(ram_address), 32'h15);
        // A reads 0x15 straight after
        cyc(); a_we = 1'b0;
        @(negedge clk);
        chk("wr ram word 15", 32'(ram_array[5'h15]), 32'hA);
        chk("rd a_gnt", 32'(a_gnt), 1);
        cyc(); a_req = 1'b0;
        @(negedge clk);
        chk("rd a_rvalid", 32'(a_rvalid), 1);
        chk("rd a_rdata", 32'(a_rdata), 32'hA);
        chk("rd b_rvalid", 32'(b_rvalid), 0);

        // B writes 0x5 at 0x0A in N, A reads 0x0A in N+1
        cyc(); b_req = 1'b1; b_we = 1'b1; b_addr = 5'h0A; b_wdata = 4'h5;
        @(negedge clk);
        chk("raw b_gnt", 32'(b_gnt), 1);
        cyc(); b_req = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 5'h0A;
        @(negedge clk);
        chk("raw a_gnt", 32'(a_gnt), 1);
        cyc(); a_req = 1'b0;
        @(negedge clk);
        chk("raw a_rvalid", 32'(a_rvalid), 1);
        chk("raw a_rdata", 32'(a_rdata), 32'h5);

        // B reads 0x0A alone, leaving B as most recently served
        cyc(); b_req = 1'b1; b_we = 1'b0; b_addr = 5'h0A;
        @(negedge clk);
        chk("b rd b_gnt", 32'(b_gnt), 1);

        // Both request continuously: A,B,A,B with alternating read-backs
        cyc(); a_req = 1'b1; a_we = 1'b0; a_addr = 5'h15;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr a_gnt", 32'(a_gnt), 32'((k % 2) == 0));
            chk("rr b_gnt", 32'(b_gnt), 32'((k % 2) == 1));
            chk("rr a_rvalid", 32'(a_rvalid), 32'((k % 2) == 1));
            chk("rr b_rvalid", 32'(b_rvalid), 32'((k % 2) == 0));
            chk("rr rdata", 32'(a_rdata), ((k % 2) == 1) ? 32'hA : 32'h5);
            cyc();
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("rr tail b_rvalid", 32'(b_rvalid), 1);
        chk("rr tail b_rdata", 32'(b_rdata), 32'h5);

        // Clear with A requesting; A's read in the start cycle still completes
        cyc(); a_req = 1'b1; a_we = 1'b0; a_addr = 5'h15; clear_start = 1'b1;
        @(negedge clk);
        chk("clr start a_gnt", 32'(a_gnt), 1);
        cyc(); clear_start = 1'b0;
        busy_cycles = 0;
        seen_done   = 1'b0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("clr first a_rvalid", 32'(a_rvalid), 1);
                chk("clr first a_rdata", 32'(a_rdata), 32'hA);
            end
            if (clear_busy) busy_cycles++;
            if (clear_done) begin
                seen_done = 1'b1;
                chk("clr done a_gnt", 32'(a_gnt), 1);
                chk("clr done busy", 32'(clear_busy), 0);
            end else begin
                cyc();
                clear_start = (k == 4);
            end
        end
        clear_start = 1'b0;
        chk("clr busy cycles", 32'(busy_cycles), 32);
        chk("clr done seen", 32'(seen_done), 1);
        cyc(); a_req = 1'b0;
        @(negedge clk);
        chk("clr read a_rvalid", 32'(a_rvalid), 1);
        chk("clr read a_rdata", 32'(a_rdata), 32'h0);

        // Restore 0x15 = 0xA and write 0x02 = 0x7, then abort a sweep
        cyc(); a_req = 1'b1; a_we = 1'b1; a_addr = 5'h15; a_wdata = 4'hA;
        @(negedge clk);
        chk("ab wr1 a_gnt", 32'(a_gnt), 1);
        cyc(); a_addr = 5'h02; a_wdata = 4'h7;
        @(negedge clk);
        chk("ab wr2 a_gnt", 32'(a_gnt), 1);
        cyc(); a_req = 1'b0; clear_start = 1'b1;
        cyc(); clear_start = 1'b0;
        repeat (10) cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("ab reset busy still", 32'(clear_busy), 1);
        chk("ab reset no write", 32'(ram_write_enable), 0);
        // After reset both request: A has priority
        cyc(); reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'h15;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'h0C;
        @(negedge clk);
        chk("ab busy cleared", 32'(clear_busy), 0);
        chk("ab a_gnt first", 32'(a_gnt), 1);
        chk("ab b_gnt first", 32'(b_gnt), 0);
        cyc(); a_addr = 5'h02;
        @(negedge clk);
        chk("ab b_gnt second", 32'(b_gnt), 1);
        chk("ab rdata 15", 32'(a_rdata), 32'hA);
        cyc(); b_req = 1'b0;
        @(negedge clk);
        chk("ab a_gnt third", 32'(a_gnt), 1);
        chk("ab rdata 0C", 32'(b_rdata), 32'h0);
        cyc(); a_req = 1'b0;
        @(negedge clk);
        chk("ab rdata 02", 32'(a_rdata), 32'h0);
        cyc();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
